// File: rtl/riscv_pkg.sv
// ---------------------------------------------------------------------------
// riscv_pkg
//   Shared constants for the ID/EX stage slice: RV opcode values, the bit
//   layout of the 8-bit decoded control word and the bubble encoding.
//   Also holds the operand-usage helpers. The hazard unit uses them to decide
//   whether an instruction actually reads rs1/rs2.
// ---------------------------------------------------------------------------
package riscv_pkg;

    // Control word layout: {RegWrite,MemtoReg,Branch,MemRead,MemWrite,ALUSrc,ALUOp[1:0]}
    localparam int CTRL_W        = 8;
    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_BRANCH   = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_ALUSRC   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    // All-zero control is a NOP: no register write and no memory access.
    localparam logic [CTRL_W-1:0] BUBBLE = 8'h00;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // Only LUI, AUIPC and JAL have no rs1. In those formats the rs1 field
    // holds immediate bits, so it must not be compared against anything.
    function automatic logic uses_rs1(input logic [6:0] opcode);
        return !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
    endfunction

    // rs2 is a real register only in the R, S and B formats.
    function automatic logic uses_rs2(input logic [6:0] opcode);
        return (opcode == OP_RTYPE) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
    endfunction

endpackage

// File: rtl/hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
//   Combinational load-use detector. It flags a hazard when the instruction
//   now in ID/EX is a load with a non-zero destination, and the instruction
//   in ID really reads that register.
//   Ports:
//     Opcode       in  7  opcode of the instruction in ID
//     Rs1, Rs2     in  5  source register fields of the instruction in ID
//     IDEX_MemRead in  1  MemRead bit of the registered ID/EX control
//     IDEX_RD      in  5  registered ID/EX destination register
//     Hazard       out 1  load-use hazard; the caller applies flush priority
// ---------------------------------------------------------------------------
module hazard_detect_unit
    import riscv_pkg::*;
(
    input  logic [6:0] Opcode,
    input  logic [4:0] Rs1,
    input  logic [4:0] Rs2,
    input  logic       IDEX_MemRead,
    input  logic [4:0] IDEX_RD,
    output logic       Hazard
);

    logic use_rs1;
    logic use_rs2;
    logic rs1_match;
    logic rs2_match;

    assign use_rs1   = uses_rs1(Opcode);
    assign use_rs2   = uses_rs2(Opcode);
    assign rs1_match = use_rs1 && (Rs1 == IDEX_RD);
    assign rs2_match = use_rs2 && (Rs2 == IDEX_RD);

    // A load into x0 never produces a value, so it cannot cause a hazard.
    assign Hazard = IDEX_MemRead && (IDEX_RD != 5'd0) && (rs1_match || rs2_match);

endmodule

// File: rtl/id_ex_stage.sv
// ---------------------------------------------------------------------------
// id_ex_stage
//   ID/EX pipeline register. It holds the load-use stall logic, squashes on a
//   taken branch and bypasses the WB result into the operands. It also keeps
//   saturating stall and flush counters.
//   Ports:
//     Clk, Reset                 clock; synchronous active-high reset
//     IFID_PC/IFID_Instr         PC and instruction in ID
//     ReadData1/ReadData2/Imm    register-file read data and immediate
//     Ctrl                       decoded control {RegWrite..ALUOp}
//     WB_RegWrite/WB_RD/WB_Data  write-back port, used for the bypass
//     BranchTaken                squashes the instruction in ID
//     PCWrite/IFIDWrite          upstream hold enables (0 = stall)
//     IDEX_*                     registered outputs to the EX stage
//     StallCount/FlushCount      saturating performance counters
// ---------------------------------------------------------------------------
module id_ex_stage
    import riscv_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int CNTW = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic [XLEN-1:0]   IFID_PC,
    input  logic [31:0]       IFID_Instr,
    input  logic [XLEN-1:0]   ReadData1,
    input  logic [XLEN-1:0]   ReadData2,
    input  logic [XLEN-1:0]   Imm,
    input  logic [CTRL_W-1:0] Ctrl,
    input  logic              WB_RegWrite,
    input  logic [4:0]        WB_RD,
    input  logic [XLEN-1:0]   WB_Data,
    input  logic              BranchTaken,
    output logic              PCWrite,
    output logic              IFIDWrite,
    output logic [XLEN-1:0]   IDEX_PC,
    output logic [XLEN-1:0]   IDEX_A,
    output logic [XLEN-1:0]   IDEX_B,
    output logic [XLEN-1:0]   IDEX_Imm,
    output logic [4:0]        IDEX_RS1,
    output logic [4:0]        IDEX_RS2,
    output logic [4:0]        IDEX_RD,
    output logic [3:0]        IDEX_Funct,
    output logic [CTRL_W-1:0] IDEX_Ctrl,
    output logic [CNTW-1:0]   StallCount,
    output logic [CNTW-1:0]   FlushCount
);

    // ---------------- instruction field split ----------------
    logic [6:0] opcode;
    logic [4:0] rs_idx [2];
    logic [4:0] rd_idx;
    logic [3:0] funct;
    logic       unused_instr_bits;

    assign opcode    = IFID_Instr[6:0];
    assign rs_idx[0] = IFID_Instr[19:15];
    assign rs_idx[1] = IFID_Instr[24:20];
    assign rd_idx    = IFID_Instr[11:7];
    assign funct     = {IFID_Instr[30], IFID_Instr[14:12]};
    // funct7 bits other than bit 30 are not forwarded to EX.
    assign unused_instr_bits = ^{IFID_Instr[31], IFID_Instr[29:25]};

    // ---------------- state ----------------
    logic [XLEN-1:0]   pc_reg;
    logic [XLEN-1:0]   op_reg [2];
    logic [XLEN-1:0]   imm_reg;
    logic [4:0]        rs1_reg;
    logic [4:0]        rs2_reg;
    logic [4:0]        rd_reg;
    logic [3:0]        funct_reg;
    logic [CTRL_W-1:0] ctrl_reg;
    logic [CNTW-1:0]   stall_cnt_reg;
    logic [CNTW-1:0]   flush_cnt_reg;

    logic [XLEN-1:0]   op_next [2];
    logic [CTRL_W-1:0] ctrl_next;
    logic [CNTW-1:0]   stall_cnt_next;
    logic [CNTW-1:0]   flush_cnt_next;

    // ---------------- hazard / flush ----------------
    logic hazard;
    logic stall;
    logic flush;

    hazard_detect_unit u_hazard_detect_unit (
        .Opcode       (opcode),
        .Rs1          (rs_idx[0]),
        .Rs2          (rs_idx[1]),
        .IDEX_MemRead (ctrl_reg[CTRL_MEMREAD]),
        .IDEX_RD      (rd_reg),
        .Hazard       (hazard)
    );

    // A taken branch discards the instruction in ID anyway, so stalling it
    // would only waste a cycle. During reset the front end must keep running.
    assign stall = hazard && !BranchTaken && !Reset;
    assign flush = BranchTaken && !Reset;

    assign PCWrite   = !stall;
    assign IFIDWrite = !stall;

    // ---------------- WB -> ID bypass ----------------
    // The register file writes on the clock edge but reads combinationally.
    // The value retiring in WB this cycle is therefore not visible on
    // ReadData yet, so take it from the WB port instead.
    logic [XLEN-1:0] rf_data [2];
    assign rf_data[0] = ReadData1;
    assign rf_data[1] = ReadData2;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_bypass
            logic wb_hit;
            assign wb_hit      = WB_RegWrite && (WB_RD != 5'd0) && (WB_RD == rs_idx[gi]);
            assign op_next[gi] = wb_hit ? WB_Data : rf_data[gi];
        end
    endgenerate

    // ---------------- control and counters ----------------
    always_comb begin
        ctrl_next      = Ctrl;
        stall_cnt_next = stall_cnt_reg;
        flush_cnt_next = flush_cnt_reg;
        if (stall || BranchTaken) begin
            ctrl_next = BUBBLE;
        end
        if (stall && (stall_cnt_reg != {CNTW{1'b1}})) begin
            stall_cnt_next = stall_cnt_reg + 1'b1;
        end
        if (flush && (flush_cnt_reg != {CNTW{1'b1}})) begin
            flush_cnt_next = flush_cnt_reg + 1'b1;
        end
    end

    // ---------------- pipeline register ----------------
    // The data fields load every cycle, including stall cycles. Only the
    // control word is bubbled, so the held instruction is re-captured later.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_reg        <= '0;
            op_reg[0]     <= '0;
            op_reg[1]     <= '0;
            imm_reg       <= '0;
            rs1_reg       <= '0;
            rs2_reg       <= '0;
            rd_reg        <= '0;
            funct_reg     <= '0;
            ctrl_reg      <= BUBBLE;
            stall_cnt_reg <= '0;
            flush_cnt_reg <= '0;
        end else begin
            pc_reg        <= IFID_PC;
            op_reg[0]     <= op_next[0];
            op_reg[1]     <= op_next[1];
            imm_reg       <= Imm;
            rs1_reg       <= rs_idx[0];
            rs2_reg       <= rs_idx[1];
            rd_reg        <= rd_idx;
            funct_reg     <= funct;
            ctrl_reg      <= ctrl_next;
            stall_cnt_reg <= stall_cnt_next;
            flush_cnt_reg <= flush_cnt_next;
        end
    end

    assign IDEX_PC    = pc_reg;
    assign IDEX_A     = op_reg[0];
    assign IDEX_B     = op_reg[1];
    assign IDEX_Imm   = imm_reg;
    assign IDEX_RS1   = rs1_reg;
    assign IDEX_RS2   = rs2_reg;
    assign IDEX_RD    = rd_reg;
    assign IDEX_Funct = funct_reg;
    assign IDEX_Ctrl  = ctrl_reg;
    assign StallCount = stall_cnt_reg;
    assign FlushCount = flush_cnt_reg;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage (XLEN=64, CNTW=4, so that counter saturation is reachable).
module tb_id_ex_stage;

    localparam int XLEN = 64;
    localparam int CNTW = 4;

    localparam logic [7:0] C_LD   = 8'hD4;  // RegWrite MemtoReg MemRead ALUSrc
    localparam logic [7:0] C_ADD  = 8'h82;  // RegWrite, ALUOp=10
    localparam logic [7:0] C_ADDI = 8'h86;  // RegWrite, ALUSrc, ALUOp=10

    logic            Clk;
    logic            Reset;
    logic [XLEN-1:0] IFID_PC, ReadData1, ReadData2, Imm, WB_Data;
    logic [31:0]     IFID_Instr;
    logic [7:0]      Ctrl;
    logic            WB_RegWrite, BranchTaken;
    logic [4:0]      WB_RD;
    logic            PCWrite, IFIDWrite;
    logic [XLEN-1:0] IDEX_PC, IDEX_A, IDEX_B, IDEX_Imm;
    logic [4:0]      IDEX_RS1, IDEX_RS2, IDEX_RD;
    logic [3:0]      IDEX_Funct;
    logic [7:0]      IDEX_Ctrl;
    logic [CNTW-1:0] StallCount, FlushCount;

    id_ex_stage #(.XLEN(XLEN), .CNTW(CNTW)) dut (
        .Clk(Clk), .Reset(Reset), .IFID_PC(IFID_PC), .IFID_Instr(IFID_Instr),
        .ReadData1(ReadData1), .ReadData2(ReadData2), .Imm(Imm), .Ctrl(Ctrl),
        .WB_RegWrite(WB_RegWrite), .WB_RD(WB_RD), .WB_Data(WB_Data),
        .BranchTaken(BranchTaken), .PCWrite(PCWrite), .IFIDWrite(IFIDWrite),
        .IDEX_PC(IDEX_PC), .IDEX_A(IDEX_A), .IDEX_B(IDEX_B), .IDEX_Imm(IDEX_Imm),
        .IDEX_RS1(IDEX_RS1), .IDEX_RS2(IDEX_RS2), .IDEX_RD(IDEX_RD),
        .IDEX_Funct(IDEX_Funct), .IDEX_Ctrl(IDEX_Ctrl),
        .StallCount(StallCount), .FlushCount(FlushCount)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct packed {
        logic            pcw;
        logic            ifw;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [3:0]      funct;
        logic [7:0]      ctrl;
        logic [CNTW-1:0] sc;
        logic [CNTW-1:0] fc;
    } obs_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    // Reference model state: what ID/EX should hold after the previous edge.
    logic [7:0]      m_ctrl = '0;
    logic [4:0]      m_rd   = '0;
    logic [CNTW-1:0] m_sc   = '0;
    logic [CNTW-1:0] m_fc   = '0;
    logic            obs_pcw, obs_ifw;

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2,
                                       input logic [2:0] f3, input logic b30);
        return {1'b0, b30, 5'b0, rs2, rs1, f3, rd, op};
    endfunction

    function automatic obs_t actual();
        return {obs_pcw, obs_ifw, IDEX_PC, IDEX_A, IDEX_B, IDEX_Imm, IDEX_RS1, IDEX_RS2,
                IDEX_RD, IDEX_Funct, IDEX_Ctrl, StallCount, FlushCount};
    endfunction

    // Drive one ID-stage cycle. Push the model's prediction and sample the
    // enables mid-cycle. Return #1 after the capturing edge.
    task automatic step(input logic rst, input logic [31:0] instr, input logic [63:0] pc,
                        input logic [63:0] rd1, input logic [63:0] rd2, input logic [63:0] imm,
                        input logic [7:0] ctrl, input logic wbw, input logic [4:0] wbrd,
                        input logic [63:0] wbd, input logic br);
        obs_t e;
        logic [4:0] s1, s2;
        logic u1, u2, haz, stl;
        @(negedge Clk);
        Reset = rst; IFID_Instr = instr; IFID_PC = pc; ReadData1 = rd1; ReadData2 = rd2;
        Imm = imm; Ctrl = ctrl; WB_RegWrite = wbw; WB_RD = wbrd; WB_Data = wbd; BranchTaken = br;
        s1  = instr[19:15];
        s2  = instr[24:20];
        u1  = !(instr[6:0] inside {7'h37, 7'h17, 7'h6f});
        u2  = instr[6:0] inside {7'h33, 7'h23, 7'h63};
        haz = m_ctrl[4] && (m_rd != 5'd0) && ((u1 && m_rd == s1) || (u2 && m_rd == s2));
        stl = haz && !br && !rst;
        e = '0;
        e.pcw = !stl;
        e.ifw = !stl;
        if (!rst) begin
            e.pc    = pc;
            e.a     = (wbw && wbrd != 5'd0 && wbrd == s1) ? wbd : rd1;
            e.b     = (wbw && wbrd != 5'd0 && wbrd == s2) ? wbd : rd2;
            e.imm   = imm;
            e.rs1   = s1;
            e.rs2   = s2;
            e.rd    = instr[11:7];
            e.funct = {instr[30], instr[14:12]};
            e.ctrl  = (stl || br) ? 8'h00 : ctrl;
            e.sc    = (stl && m_sc != 4'hF) ? m_sc + 4'd1 : m_sc;
            e.fc    = (br && m_fc != 4'hF) ? m_fc + 4'd1 : m_fc;
        end
        m_ctrl = e.ctrl; m_rd = e.rd; m_sc = e.sc; m_fc = e.fc;
        sb.push_back(e);
        #1;
        obs_pcw = PCWrite;
        obs_ifw = IFIDWrite;
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        obs_t e;
        step(1'b1, 32'h0, 64'h0, 64'h0, 64'h0, 64'h0, 8'h00, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
    endtask

    task automatic test_reset();
        obs_t e;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, $urandom, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, 8'($urandom), 1'b1, 5'($urandom), {$urandom, $urandom},
                 1'($urandom));
            e = sb.pop_front();
            n_vec++;
            if (actual() !== obs_t'({2'b11, {($bits(obs_t)-2){1'b0}}})) begin
                n_err++;
                $display("FAIL reset_state[%0d]: got %h want all-zero with PCWrite=IFIDWrite=1", i, actual());
            end
        end
    endtask

    task automatic test_load_use();
        obs_t e;
        do_reset();
        step(1'b0, mk(7'h03, 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h100, 64'h11, 64'h22, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if (actual() !== e) begin n_err++; $display("FAIL ld_capture: got %h want %h", actual(), e); end
        step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h104, 64'h33, 64'h44, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, obs_ifw, IDEX_Ctrl, StallCount} !== {1'b0, 1'b0, 8'h00, 4'd1}) begin
            n_err++;
            $display("FAIL ld_use_stall: got pcw=%b ifw=%b ctrl=%h sc=%0d want 0 0 00 1", obs_pcw, obs_ifw, IDEX_Ctrl, StallCount);
        end
        n_vec++;
        if (actual() !== e) begin n_err++; $display("FAIL ld_use_fields: got %h want %h", actual(), e); end
        step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h104, 64'h33, 64'h44, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, IDEX_Ctrl, IDEX_RD, StallCount} !== {1'b1, C_ADD, 5'd6, 4'd1}) begin
            n_err++;
            $display("FAIL ld_use_release: got pcw=%b ctrl=%h rd=%0d sc=%0d want 1 82 6 1", obs_pcw, IDEX_Ctrl, IDEX_RD, StallCount);
        end
    endtask

    task automatic test_no_hazard();
        obs_t e;
        logic [31:0] tail [4];
        do_reset();
        tail[0] = mk(7'h13, 5'd6, 5'd7, 5'd5, 3'b000, 1'b0);  // addi x6,x7,5: imm bits alias rs2=5
        tail[1] = mk(7'h37, 5'd6, 5'd5, 5'd5, 3'b000, 1'b0);  // lui: rs1/rs2 fields are imm
        tail[2] = mk(7'h33, 5'd6, 5'd0, 5'd0, 3'b000, 1'b0);  // add x6,x0,x0 after ld x0
        tail[3] = mk(7'h6f, 5'd1, 5'd5, 5'd5, 3'b000, 1'b0);  // jal: no register sources
        for (int i = 0; i < 4; i++) begin
            step(1'b0, mk(7'h03, (i == 2) ? 5'd0 : 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h200, 64'h1, 64'h2, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
            e = sb.pop_front();
            step(1'b0, tail[i], 64'h204, 64'h7, 64'h8, 64'h5, C_ADDI, 1'b0, 5'd0, 64'h0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if ({obs_pcw, IDEX_Ctrl, StallCount} !== {1'b1, C_ADDI, 4'd0}) begin
                n_err++;
                $display("FAIL no_hazard[%0d]: got pcw=%b ctrl=%h sc=%0d want 1 86 0", i, obs_pcw, IDEX_Ctrl, StallCount);
            end
        end
    endtask

    task automatic test_flush();
        obs_t e;
        do_reset();
        step(1'b0, mk(7'h03, 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h300, 64'h1, 64'h2, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h304, 64'h3, 64'h4, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b1);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, obs_ifw, IDEX_Ctrl, FlushCount, StallCount} !== {1'b1, 1'b1, 8'h00, 4'd1, 4'd0}) begin
            n_err++;
            $display("FAIL flush_over_stall: got pcw=%b ifw=%b ctrl=%h fc=%0d sc=%0d want 1 1 00 1 0",
                     obs_pcw, obs_ifw, IDEX_Ctrl, FlushCount, StallCount);
        end
        n_vec++;
        if (actual() !== e) begin n_err++; $display("FAIL flush_fields: got %h want %h", actual(), e); end
    endtask

    task automatic test_bypass();
        obs_t e;
        do_reset();
        step(1'b0, mk(7'h33, 5'd3, 5'd9, 5'd4, 3'b000, 1'b0), 64'h400, 64'h9, 64'h44, 64'h0, C_ADD, 1'b1, 5'd9, 64'hDEAD, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({IDEX_A, IDEX_B} !== {64'hDEAD, 64'h44}) begin
            n_err++; $display("FAIL bypass_rs1: got A=%h B=%h want A=dead B=44", IDEX_A, IDEX_B);
        end
        step(1'b0, mk(7'h33, 5'd3, 5'd4, 5'd9, 3'b000, 1'b0), 64'h404, 64'h44, 64'h9, 64'h0, C_ADD, 1'b1, 5'd9, 64'hBEEF, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({IDEX_A, IDEX_B} !== {64'h44, 64'hBEEF}) begin
            n_err++; $display("FAIL bypass_rs2: got A=%h B=%h want A=44 B=beef", IDEX_A, IDEX_B);
        end
        step(1'b0, mk(7'h33, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0), 64'h408, 64'h9, 64'h7, 64'h0, C_ADD, 1'b1, 5'd0, 64'hDEAD, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({IDEX_A, IDEX_B} !== {64'h9, 64'h7}) begin
            n_err++; $display("FAIL bypass_x0: got A=%h B=%h want A=9 B=7", IDEX_A, IDEX_B);
        end
        // The bypass must still apply while the load-use stall is in effect.
        step(1'b0, mk(7'h03, 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h40c, 64'h1, 64'h2, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd12, 3'b000, 1'b1), 64'h410, 64'h1, 64'h2, 64'h0, C_ADD, 1'b1, 5'd12, 64'hCAFE, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, IDEX_Ctrl, IDEX_B, IDEX_Funct} !== {1'b0, 8'h00, 64'hCAFE, 4'b1000}) begin
            n_err++;
            $display("FAIL bypass_on_stall: got pcw=%b ctrl=%h B=%h funct=%b want 0 00 cafe 1000", obs_pcw, IDEX_Ctrl, IDEX_B, IDEX_Funct);
        end
    endtask

    task automatic test_reset_mid_stall();
        obs_t e;
        do_reset();
        step(1'b0, mk(7'h03, 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h500, 64'h1, 64'h2, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        step(1'b1, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h504, 64'h3, 64'h4, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, IDEX_Ctrl, IDEX_RD, StallCount} !== {1'b1, 8'h00, 5'd0, 4'd0}) begin
            n_err++;
            $display("FAIL reset_mid_stall: got pcw=%b ctrl=%h rd=%0d sc=%0d want 1 00 0 0", obs_pcw, IDEX_Ctrl, IDEX_RD, StallCount);
        end
        step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h504, 64'h3, 64'h4, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b0);
        e = sb.pop_front();
        n_vec++;
        if ({obs_pcw, IDEX_Ctrl} !== {1'b1, C_ADD}) begin
            n_err++; $display("FAIL after_reset_no_stall: got pcw=%b ctrl=%h want 1 82", obs_pcw, IDEX_Ctrl);
        end
    endtask

    task automatic test_saturation();
        obs_t e;
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1'b0, mk(7'h03, 5'd5, 5'd1, 5'd0, 3'b011, 1'b0), 64'h600, 64'h1, 64'h2, 64'h0, C_LD, 1'b0, 5'd0, 64'h0, 1'b0);
            e = sb.pop_front();
            step(1'b0, mk(7'h33, 5'd6, 5'd5, 5'd2, 3'b000, 1'b0), 64'h604, 64'h3, 64'h4, 64'h0, C_ADD, 1'b0, 5'd0, 64'h0, 1'b0);
            e = sb.pop_front();
            n_vec++;
            if (actual() !== e) begin n_err++; $display("FAIL sat_pair[%0d]: got %h want %h", i, actual(), e); end
        end
        n_vec++;
        if (StallCount !== 4'hF) begin
            n_err++; $display("FAIL stall_saturate: got %h want f", StallCount);
        end
    endtask

    task automatic test_back_to_back();
        obs_t e;
        logic [6:0]  ops [7];
        logic [31:0] ins;
        logic [7:0]  c;
        ops = '{7'h03, 7'h33, 7'h13, 7'h23, 7'h63, 7'h37, 7'h6f};
        do_reset();
        for (int i = 0; i < 60; i++) begin
            ins = mk(ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 3'($urandom), 1'($urandom));
            c = 8'($urandom);
            step(($urandom_range(0, 19) == 0), ins, {$urandom, $urandom}, {$urandom, $urandom},
                 {$urandom, $urandom}, {$urandom, $urandom}, c, 1'($urandom),
                 5'($urandom_range(0, 3)), {$urandom, $urandom}, ($urandom_range(0, 5) == 0));
            e = sb.pop_front();
            n_vec++;
            if (actual() !== e) begin n_err++; $display("FAIL b2b[%0d]: got %h want %h", i, actual(), e); end
        end
    endtask

    initial begin
        Reset = 1'b1; IFID_PC = '0; IFID_Instr = '0; ReadData1 = '0; ReadData2 = '0;
        Imm = '0; Ctrl = '0; WB_RegWrite = 1'b0; WB_RD = '0; WB_Data = '0; BranchTaken = 1'b0;
        test_reset();
        test_load_use();
        test_no_hazard();
        test_flush();
        test_bypass();
        test_reset_mid_stall();
        test_saturation();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
